// File: rtl/ext_ipa_pkg.sv
// Shared types and helpers for the ext AR burst splitter.
package ext_ipa_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Beats of width 1<<size from the beat-aligned addr12 up to the next 4 KB page; always >= 1.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr12, input logic [2:0] size);
    logic [11:0] mask;
    logic [12:0] bytes;
    mask  = 12'hfff << size;
    bytes = 13'd4096 - {1'b0, addr12 & mask};
    return bytes >> size;
  endfunction

endpackage

// File: rtl/ext_ar_split_calc_ipa.sv
// Combinational sizing of the next INCR sub-burst.
// EXT_AR_SPLIT_4K_EN additionally limits each sub-burst to its 4 KB page.
module ext_ar_split_calc_ipa
  import ext_ipa_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_LEN    = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [8:0]            rem,
  output logic [8:0]            beats,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  last
);

  localparam logic [12:0] MAX_BEATS = 13'(MAX_LEN);

  logic [12:0]           lim;
  logic [ADDR_WIDTH-1:0] low_mask;
  logic [ADDR_WIDTH-1:0] step;

`ifdef EXT_AR_SPLIT_4K_EN
  logic [12:0] b4k;
  always_comb begin
    b4k = beats_to_4k(addr[11:0], size);
    lim = (b4k < MAX_BEATS) ? b4k : MAX_BEATS;
  end
`else
  always_comb begin
    lim = MAX_BEATS;
  end
`endif

  always_comb begin
    beats     = ({4'b0, rem} < lim) ? rem : lim[8:0];
    last      = (beats == rem);
    low_mask  = ~({ADDR_WIDTH{1'b1}} << size);
    step      = {{(ADDR_WIDTH-9){1'b0}}, beats} << size;
    // Later sub-bursts start beat-aligned; the sum wraps modulo 2^ADDR_WIDTH.
    next_addr = (addr & ~low_mask) + step;
  end

endmodule

// File: rtl/ext_ar_burst_split_ipa.sv
// AR burst splitter: INCR bursts are cut into sub-bursts of at most MAX_LEN beats.
// Optional 4 KB splitting is enabled with the macro EXT_AR_SPLIT_4K_EN.
module ext_ar_burst_split_ipa
  import ext_ipa_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 6,
  parameter int MAX_LEN    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slave_valid_i,
  input  logic [ADDR_WIDTH-1:0] slave_addr_i,
  input  logic [2:0]            slave_prot_i,
  input  logic [3:0]            slave_region_i,
  input  logic [7:0]            slave_len_i,
  input  logic [2:0]            slave_size_i,
  input  logic [1:0]            slave_burst_i,
  input  logic                  slave_lock_i,
  input  logic [3:0]            slave_cache_i,
  input  logic [3:0]            slave_qos_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  output logic                  slave_ready_o,
  output logic                  master_valid_o,
  output logic [ADDR_WIDTH-1:0] master_addr_o,
  output logic [2:0]            master_prot_o,
  output logic [3:0]            master_region_o,
  output logic [7:0]            master_len_o,
  output logic [2:0]            master_size_o,
  output logic [1:0]            master_burst_o,
  output logic                  master_lock_o,
  output logic [3:0]            master_cache_o,
  output logic [3:0]            master_qos_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic                  master_last_o,
  input  logic                  master_ready_i,
  output logic                  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // master payload is held stable while master_valid_o is high and master_ready_i is low.
  state_t                state, nxt;
  logic [ADDR_WIDTH-1:0] addr_q, next_addr;
  logic [2:0]            prot_q, size_q;
  logic [3:0]            region_q, cache_q, qos_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic                  lock_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [8:0]            rem_q, beats;
  logic                  incr_last, is_incr;

  ext_ar_split_calc_ipa #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_LEN(MAX_LEN)) u_calc (
    .addr      (addr_q),
    .size      (size_q),
    .rem       (rem_q),
    .beats     (beats),
    .next_addr (next_addr),
    .last      (incr_last)
  );

  assign is_incr     = (burst_q == BURST_INCR);
  assign dbg_state_o = state;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (slave_valid_i) nxt = ISSUE;
      ISSUE:   if (master_ready_i && (!is_incr || incr_last)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0; prot_q <= '0; region_q <= '0; len_q <= '0; size_q <= '0;
      burst_q <= '0; lock_q <= 1'b0; cache_q <= '0; qos_q <= '0;
      id_q <= '0; user_q <= '0; rem_q <= '0;
    end else if (state == IDLE && slave_valid_i) begin
      addr_q   <= slave_addr_i;   prot_q  <= slave_prot_i;  region_q <= slave_region_i;
      len_q    <= slave_len_i;    size_q  <= slave_size_i;  burst_q  <= slave_burst_i;
      lock_q   <= slave_lock_i;   cache_q <= slave_cache_i; qos_q    <= slave_qos_i;
      id_q     <= slave_id_i;     user_q  <= slave_user_i;
      rem_q    <= {1'b0, slave_len_i} + 9'd1;
    end else if (state == ISSUE && master_ready_i && is_incr && !incr_last) begin
      rem_q  <= rem_q - beats;
      addr_q <= next_addr;
    end
  end

  always_comb begin
    slave_ready_o   = (state == IDLE) && rst_ni;
    master_valid_o  = 1'b0;
    master_addr_o   = '0;
    master_prot_o   = '0;
    master_region_o = '0;
    master_len_o    = '0;
    master_size_o   = '0;
    master_burst_o  = '0;
    master_lock_o   = 1'b0;
    master_cache_o  = '0;
    master_qos_o    = '0;
    master_id_o     = '0;
    master_user_o   = '0;
    master_last_o   = 1'b0;
    if (state == ISSUE) begin
      master_valid_o  = 1'b1;
      master_addr_o   = addr_q;
      master_prot_o   = prot_q;
      master_region_o = region_q;
      master_size_o   = size_q;
      master_burst_o  = burst_q;
      master_lock_o   = lock_q;
      master_cache_o  = cache_q;
      master_qos_o    = qos_q;
      master_id_o     = id_q;
      master_user_o   = user_q;
      // FIXED, WRAP and the reserved encoding pass through as one unsplit burst.
      master_len_o    = is_incr ? 8'(beats - 9'd1) : len_q;
      master_last_o   = is_incr ? incr_last : 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_ar_burst_split_ipa.sv
// Directed bench for ext_ar_burst_split_ipa (MAX_LEN=16); honours EXT_AR_SPLIT_4K_EN.
module tb_ext_ar_burst_split_ipa;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        slave_valid_i;
  logic [31:0] slave_addr_i;
  logic [2:0]  slave_prot_i;
  logic [3:0]  slave_region_i;
  logic [7:0]  slave_len_i;
  logic [2:0]  slave_size_i;
  logic [1:0]  slave_burst_i;
  logic        slave_lock_i;
  logic [3:0]  slave_cache_i;
  logic [3:0]  slave_qos_i;
  logic [3:0]  slave_id_i;
  logic [5:0]  slave_user_i;
  logic        slave_ready_o;
  logic        master_valid_o;
  logic [31:0] master_addr_o;
  logic [2:0]  master_prot_o;
  logic [3:0]  master_region_o;
  logic [7:0]  master_len_o;
  logic [2:0]  master_size_o;
  logic [1:0]  master_burst_o;
  logic        master_lock_o;
  logic [3:0]  master_cache_o;
  logic [3:0]  master_qos_o;
  logic [3:0]  master_id_o;
  logic [5:0]  master_user_o;
  logic        master_last_o;
  logic        master_ready_i;
  logic        dbg_state_o;

  int checks = 0;
  int errors = 0;
  // Scoreboard record: {user, id, addr, len, last}
  logic [50:0] exp_q[$];

  ext_ar_burst_split_ipa #(.ID_WIDTH(4), .ADDR_WIDTH(32), .USER_WIDTH(6), .MAX_LEN(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slave_valid_i(slave_valid_i), .slave_addr_i(slave_addr_i), .slave_prot_i(slave_prot_i),
    .slave_region_i(slave_region_i), .slave_len_i(slave_len_i), .slave_size_i(slave_size_i),
    .slave_burst_i(slave_burst_i), .slave_lock_i(slave_lock_i), .slave_cache_i(slave_cache_i),
    .slave_qos_i(slave_qos_i), .slave_id_i(slave_id_i), .slave_user_i(slave_user_i),
    .slave_ready_o(slave_ready_o),
    .master_valid_o(master_valid_o), .master_addr_o(master_addr_o), .master_prot_o(master_prot_o),
    .master_region_o(master_region_o), .master_len_o(master_len_o), .master_size_o(master_size_o),
    .master_burst_o(master_burst_o), .master_lock_o(master_lock_o), .master_cache_o(master_cache_o),
    .master_qos_o(master_qos_o), .master_id_o(master_id_o), .master_user_o(master_user_o),
    .master_last_o(master_last_o), .master_ready_i(master_ready_i), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  function automatic logic [50:0] ar(input logic [5:0] user, input logic [3:0] id,
                                     input logic [31:0] addr, input logic [7:0] len, input logic last);
    return {user, id, addr, len, last};
  endfunction

  // Scoreboard: every downstream handshake must match the head of exp_q.
  always @(negedge clk_i) begin
    logic [50:0] got, exp;
    if (rst_ni && master_valid_o && master_ready_i) begin
      got = {master_user_o, master_id_o, master_addr_o, master_len_o, master_last_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ar_unexpected: got %h, expected none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL ar_payload: got user/id/addr/len/last %h, expected %h", got, exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic send_req(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [5:0] user);
    int n = 0;
    slave_valid_i = 1'b1; slave_addr_i = addr; slave_len_i = len; slave_size_i = size;
    slave_burst_i = burst; slave_id_i = id; slave_user_i = user;
    do begin
      @(negedge clk_i);
      n++;
    end while (!slave_ready_o && n < 50);
    if (!slave_ready_o) begin
      errors++;
      $display("FAIL req_accept: slave_ready_o stayed %b, expected 1", slave_ready_o);
    end
    @(posedge clk_i); #1;
    slave_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || master_valid_o) && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || master_valid_o) begin
      errors++;
      $display("FAIL %s_drain: got %0d missing ARs valid=%b, expected 0 missing valid=0",
               name, exp_q.size(), master_valid_o);
    end
    exp_q.delete();
  endtask

  // Scenarios
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (master_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", master_valid_o); end
    checks++;
    if (master_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", master_last_o); end
    checks++;
    if (master_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", master_addr_o); end
    checks++;
    if (master_len_o !== 8'h0) begin errors++; $display("FAIL reset_len: got %h expected 0", master_len_o); end
    checks++;
    if (slave_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", slave_ready_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (slave_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", slave_ready_o); end
  endtask

  task automatic test_incr_single();
    exp_q.push_back(ar(6'h2a, 4'h3, 32'h1000, 8'd7, 1'b1));
    send_req(32'h1000, 8'd7, 3'd2, 2'b01, 4'h3, 6'h2a);
    checks++;
    if (master_valid_o !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b expected 1", master_valid_o); end
    checks++;
    if ({master_prot_o, master_region_o, master_size_o, master_burst_o, master_lock_o, master_cache_o, master_qos_o}
        !== {3'd2, 4'h5, 3'd2, 2'b01, 1'b1, 4'h3, 4'h9}) begin
      errors++;
      $display("FAIL attr_copy: got prot %h region %h size %h burst %h lock %b cache %h qos %h, expected 2 5 2 1 1 3 9",
               master_prot_o, master_region_o, master_size_o, master_burst_o, master_lock_o, master_cache_o, master_qos_o);
    end
    checks++;
    if (slave_ready_o !== 1'b0) begin errors++; $display("FAIL issue_ready: got %b expected 0", slave_ready_o); end
    wait_drain("incr_single");
  endtask

  task automatic test_incr_split();
    exp_q.push_back(ar(6'h11, 4'h5, 32'h00, 8'd15, 1'b0));
    exp_q.push_back(ar(6'h11, 4'h5, 32'h40, 8'd15, 1'b0));
    exp_q.push_back(ar(6'h11, 4'h5, 32'h80, 8'd7,  1'b1));
    send_req(32'h0, 8'd39, 3'd2, 2'b01, 4'h5, 6'h11);
    wait_drain("incr_split");
    // Unaligned start: first keeps 0x3, second is aligned to 0x40.
    exp_q.push_back(ar(6'h01, 4'h6, 32'h03, 8'd15, 1'b0));
    exp_q.push_back(ar(6'h01, 4'h6, 32'h40, 8'd0,  1'b1));
    send_req(32'h3, 8'd16, 3'd2, 2'b01, 4'h6, 6'h01);
    wait_drain("incr_unaligned");
  endtask

  task automatic test_4k();
`ifdef EXT_AR_SPLIT_4K_EN
    exp_q.push_back(ar(6'h07, 4'h9, 32'hff8,  8'd1, 1'b0));
    exp_q.push_back(ar(6'h07, 4'h9, 32'h1000, 8'd5, 1'b1));
`else
    exp_q.push_back(ar(6'h07, 4'h9, 32'hff8, 8'd7, 1'b1));
`endif
    send_req(32'hff8, 8'd7, 3'd2, 2'b01, 4'h9, 6'h07);
    wait_drain("cross_4k");
  endtask

  task automatic test_passthrough();
    exp_q.push_back(ar(6'h3f, 4'hc, 32'h34, 8'd15, 1'b1));
    send_req(32'h34, 8'd15, 3'd2, 2'b10, 4'hc, 6'h3f);
    wait_drain("wrap");
    exp_q.push_back(ar(6'h00, 4'h1, 32'h100, 8'd20, 1'b1));
    send_req(32'h100, 8'd20, 3'd2, 2'b00, 4'h1, 6'h00);
    wait_drain("fixed");
    exp_q.push_back(ar(6'h15, 4'h2, 32'h10, 8'd40, 1'b1));
    send_req(32'h10, 8'd40, 3'd2, 2'b11, 4'h2, 6'h15);
    wait_drain("reserved");
  endtask

  task automatic test_backpressure();
    int n = 0;
    exp_q.push_back(ar(6'h22, 4'h4, 32'h00, 8'd15, 1'b0));
    exp_q.push_back(ar(6'h22, 4'h4, 32'h40, 8'd15, 1'b0));
    exp_q.push_back(ar(6'h22, 4'h4, 32'h80, 8'd7,  1'b1));
    send_req(32'h0, 8'd39, 3'd2, 2'b01, 4'h4, 6'h22);
    while (exp_q.size() > 2 && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    master_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (!(master_valid_o === 1'b1 && master_addr_o === 32'h40 && master_len_o === 8'd15 &&
            master_last_o === 1'b0 && slave_ready_o === 1'b0)) begin
        errors++;
        $display("FAIL stall_hold: got valid %b addr %h len %0d last %b sready %b, expected 1 00000040 15 0 0",
                 master_valid_o, master_addr_o, master_len_o, master_last_o, slave_ready_o);
      end
    end
    master_ready_i = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_reset_mid_issue();
    int n = 0;
    exp_q.push_back(ar(6'h33, 4'h8, 32'h00, 8'd15, 1'b0));
    send_req(32'h0, 8'd39, 3'd2, 2'b01, 4'h8, 6'h33);
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (master_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", master_valid_o); end
    rst_ni = 1'b1;
    wait_drain("midreset");
    exp_q.push_back(ar(6'h0a, 4'hb, 32'h200, 8'd3, 1'b1));
    send_req(32'h200, 8'd3, 3'd2, 2'b01, 4'hb, 6'h0a);
    wait_drain("after_reset");
  endtask

  initial begin
    slave_valid_i = 1'b0; slave_addr_i = '0; slave_len_i = '0; slave_size_i = '0;
    slave_burst_i = '0; slave_id_i = '0; slave_user_i = '0;
    slave_prot_i = 3'd2; slave_region_i = 4'h5; slave_lock_i = 1'b1;
    slave_cache_i = 4'h3; slave_qos_i = 4'h9;
    master_ready_i = 1'b1;
    test_reset();
    test_incr_single();
    test_incr_split();
    test_4k();
    test_passthrough();
    test_backpressure();
    test_reset_mid_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
